// File: rtl/ecc_pkg.sv
// ============================================================================
// Package     : ecc_pkg
// Description : Shared types, register offsets and STATUS bit positions for
//               the ECC error logger.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ecc_pkg;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_SEC  = 2'b01,
        ERR_DED  = 2'b10
    } err_type_e;

    localparam logic [31:0] REG_STATUS  = 32'h00;
    localparam logic [31:0] REG_IRQ_EN  = 32'h04;
    localparam logic [31:0] REG_SEC_CNT = 32'h08;
    localparam logic [31:0] REG_DED_CNT = 32'h0C;
    localparam logic [31:0] REG_LOG_POP = 32'h10;

    localparam int STS_SEC_PEND  = 0;
    localparam int STS_DED_PEND  = 1;
    localparam int STS_LOG_EMPTY = 2;
    localparam int STS_LOG_FULL  = 3;
    localparam int STS_OVF       = 4;

endpackage

`default_nettype wire

// File: rtl/ecc_err_log_fifo.sv
// ============================================================================
// Module      : ecc_err_log_fifo
// Description : Small synchronous FIFO for error-log entries; a push into a
//               full FIFO is accepted when a pop happens on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ecc_err_log_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic             ECC_decoding_clk,
    input  logic             ECC_decoding_rstn,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    // Extra MSB distinguishes full from empty when the index bits match.
    logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge ECC_decoding_clk or negedge ECC_decoding_rstn) begin
        if (!ECC_decoding_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge ECC_decoding_clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
    end

endmodule

`default_nettype wire

// File: rtl/ecc_err_logger.sv
// ============================================================================
// Module      : ecc_err_logger
// Description : Captures ECC SEC/DED events into saturating counters and an
//               address log FIFO; APB3 readback/W1C and a level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ecc_err_logger
    import ecc_pkg::*;
#(
    parameter int ADDR_WIDTH     = 5,
    parameter int REG_ADDR_WIDTH = 10,
    parameter int CNT_WIDTH      = 16,
    parameter int LOG_DEPTH      = 4
) (
    input  logic                      ECC_decoding_clk,
    input  logic                      ECC_decoding_rstn,
    input  logic                      sw_rstn,
    input  logic                      err_valid_i,
    input  logic [1:0]                err_type_i,
    input  logic [ADDR_WIDTH-1:0]     err_addr_i,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [REG_ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]               pwdata,
    input  logic [3:0]                pstrb,
    output logic [31:0]               prdata,
    output logic                      pready,
    output logic                      pslverr,
    output logic                      irq_o
);

    localparam int ENTRY_W = ADDR_WIDTH + 2;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] sec_cnt_q, sec_cnt_d, ded_cnt_q, ded_cnt_d;
    logic                 sec_pend_q, sec_pend_d, ded_pend_q, ded_pend_d;
    logic                 ovf_q, ovf_d, irq_q, irq_d;
    logic [2:0]           irq_en_q, irq_en_d;
    logic [ENTRY_W-1:0]   fifo_rdata;
    logic                 fifo_full, fifo_empty;

    // Comb outputs are also silenced while either reset is asserted.
    logic        active, access, wr, rd, is_sec, is_ded, is_evt, pop;
    logic        sel_sts, sel_en, sel_sec, sel_ded, sel_pop, unmapped;
    logic [31:0] addr32;

    assign active   = ECC_decoding_rstn & sw_rstn;
    assign access   = psel & penable & active;
    assign wr       = access & pwrite;
    assign rd       = access & ~pwrite;
    assign addr32   = 32'(paddr);
    assign sel_sts  = (addr32 == REG_STATUS);
    assign sel_en   = (addr32 == REG_IRQ_EN);
    assign sel_sec  = (addr32 == REG_SEC_CNT);
    assign sel_ded  = (addr32 == REG_DED_CNT);
    assign sel_pop  = (addr32 == REG_LOG_POP);
    assign unmapped = ~(sel_sts | sel_en | sel_sec | sel_ded | sel_pop);
    assign is_sec   = active & err_valid_i & (err_type_i == ERR_SEC);
    assign is_ded   = active & err_valid_i & (err_type_i == ERR_DED);
    assign is_evt   = is_sec | is_ded;
    assign pop      = rd & sel_pop & ~fifo_empty;
    assign pready   = 1'b1;
    assign irq_o    = irq_q;

    logic unused_ok;
    assign unused_ok = ^{pwdata[31:5], pstrb[3:1]};

    ecc_err_log_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (LOG_DEPTH)
    ) u_log_fifo (
        .ECC_decoding_clk  (ECC_decoding_clk),
        .ECC_decoding_rstn (ECC_decoding_rstn),
        .clr_i             (~sw_rstn),
        .push_i            (is_evt),
        .pop_i             (pop),
        .wdata_i           ({err_type_i, err_addr_i}),
        .rdata_o           (fifo_rdata),
        .full_o            (fifo_full),
        .empty_o           (fifo_empty)
    );

    // Ordering: clears first, then event sets, so a same-cycle event wins.
    always_comb begin
        sec_cnt_d  = sec_cnt_q;
        ded_cnt_d  = ded_cnt_q;
        sec_pend_d = sec_pend_q;
        ded_pend_d = ded_pend_q;
        ovf_d      = ovf_q;
        irq_en_d   = irq_en_q;
        irq_d      = |({ovf_q, ded_pend_q, sec_pend_q} & irq_en_q);
        if (wr && sel_sts) begin
            if (pwdata[STS_SEC_PEND]) sec_pend_d = 1'b0;
            if (pwdata[STS_DED_PEND]) ded_pend_d = 1'b0;
            if (pwdata[STS_OVF])      ovf_d      = 1'b0;
        end
        if (wr && sel_en && pstrb[0]) irq_en_d = pwdata[2:0];
        if (is_sec) begin
            sec_pend_d = 1'b1;
            sec_cnt_d  = (wr && sel_sec) ? CNT_ONE :
                         (sec_cnt_q == CNT_MAX) ? sec_cnt_q : sec_cnt_q + 1'b1;
        end else if (wr && sel_sec) begin
            sec_cnt_d = '0;
        end
        if (is_ded) begin
            ded_pend_d = 1'b1;
            ded_cnt_d  = (wr && sel_ded) ? CNT_ONE :
                         (ded_cnt_q == CNT_MAX) ? ded_cnt_q : ded_cnt_q + 1'b1;
        end else if (wr && sel_ded) begin
            ded_cnt_d = '0;
        end
        if (is_evt && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge ECC_decoding_clk or negedge ECC_decoding_rstn) begin
        if (!ECC_decoding_rstn) begin
            sec_cnt_q  <= '0;
            ded_cnt_q  <= '0;
            sec_pend_q <= 1'b0;
            ded_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            irq_en_q   <= '0;
            irq_q      <= 1'b0;
        end else if (!sw_rstn) begin
            sec_cnt_q  <= '0;
            ded_cnt_q  <= '0;
            sec_pend_q <= 1'b0;
            ded_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            irq_en_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            sec_cnt_q  <= sec_cnt_d;
            ded_cnt_q  <= ded_cnt_d;
            sec_pend_q <= sec_pend_d;
            ded_pend_q <= ded_pend_d;
            ovf_q      <= ovf_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        prdata  = '0;
        pslverr = access & unmapped;
        if (rd) begin
            if (sel_sts) prdata[4:0] = {ovf_q, fifo_full, fifo_empty, ded_pend_q, sec_pend_q};
            if (sel_en)  prdata[2:0] = irq_en_q;
            if (sel_sec) prdata      = 32'(sec_cnt_q);
            if (sel_ded) prdata      = 32'(ded_cnt_q);
            if (sel_pop && !fifo_empty) begin
                prdata[31]               = 1'b1;
                prdata[17:16]            = fifo_rdata[ENTRY_W-1 -: 2];
                prdata[ADDR_WIDTH-1:0]   = fifo_rdata[ADDR_WIDTH-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ecc_err_logger.sv
// ============================================================================
// Module      : tb_ecc_err_logger
// Description : Directed bench for ecc_err_logger with a queue-based
//               reference model checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ecc_err_logger;

    localparam int AW = 5;
    localparam int CW = 4;   // narrow counter keeps the saturation run short
    localparam int LD = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic        clk = 1'b0, rstn = 1'b0, sw_rstn = 1'b1;
    logic        err_valid = 1'b0;
    logic [1:0]  err_type = 2'b00;
    logic [AW-1:0] err_addr = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [9:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = 4'hF;
    logic [31:0] prdata;
    logic        pready, pslverr, irq_o;

    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    ecc_err_logger #(
        .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(10), .CNT_WIDTH(CW), .LOG_DEPTH(LD)
    ) dut (
        .ECC_decoding_clk(clk), .ECC_decoding_rstn(rstn), .sw_rstn(sw_rstn),
        .err_valid_i(err_valid), .err_type_i(err_type), .err_addr_i(err_addr),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .irq_o(irq_o)
    );

    // ---------------- reference model ----------------
    int         m_sec, m_ded;
    bit         m_sp, m_dp, m_ovf, m_irq;
    bit [2:0]   m_en;
    logic [6:0] m_q[$];

    task automatic model_clear();
        m_sec = 0; m_ded = 0; m_sp = 0; m_dp = 0; m_ovf = 0; m_irq = 0; m_en = 0;
        m_q.delete();
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn || !sw_rstn) begin
            model_clear();
        end else begin
            bit acc, wr, rd, irq_next;
            int a;
            acc = psel && penable;
            wr  = acc && pwrite;
            rd  = acc && !pwrite;
            a   = int'(paddr);
            irq_next = (m_sp && m_en[0]) || (m_dp && m_en[1]) || (m_ovf && m_en[2]);
            if (rd && a == 'h10 && m_q.size() > 0) void'(m_q.pop_front());
            if (wr && a == 'h00) begin
                if (pwdata[0]) m_sp = 0;
                if (pwdata[1]) m_dp = 0;
                if (pwdata[4]) m_ovf = 0;
            end
            if (wr && a == 'h04 && pstrb[0]) m_en = pwdata[2:0];
            if (wr && a == 'h08) m_sec = 0;
            if (wr && a == 'h0C) m_ded = 0;
            if (err_valid && (err_type == 2'b01 || err_type == 2'b10)) begin
                if (err_type == 2'b01) begin m_sp = 1; if (m_sec < CMAX) m_sec++; end
                else                   begin m_dp = 1; if (m_ded < CMAX) m_ded++; end
                if (m_q.size() < LD) m_q.push_back({err_type, err_addr});
                else                 m_ovf = 1;
            end
            m_irq = irq_next;
        end
    end

    function automatic logic [31:0] exp_read(input int a);
        logic [6:0] h;
        case (a)
            'h00: return {27'd0, m_ovf, (m_q.size() == LD), (m_q.size() == 0), m_dp, m_sp};
            'h04: return {29'd0, m_en};
            'h08: return 32'(m_sec);
            'h0C: return 32'(m_ded);
            'h10: begin
                if (m_q.size() == 0) return 32'd0;
                h = m_q[0];
                return {1'b1, 13'd0, h[6:5], 11'd0, h[4:0]};
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit mapped(input int a);
        return (a == 'h00 || a == 'h04 || a == 'h08 || a == 'h0C || a == 'h10);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [31:0] e_rd;
        logic        e_err;
        e_rd = 32'd0;
        e_err = 1'b0;
        if (rstn && sw_rstn && psel && penable) begin
            e_err = !mapped(int'(paddr));
            if (!pwrite) e_rd = exp_read(int'(paddr));
        end
        chk("cyc_prdata", prdata, e_rd);
        chk("cyc_pslverr", {31'd0, pslverr}, {31'd0, e_err});
        chk("cyc_irq", {31'd0, irq_o}, {31'd0, m_irq});
        chk("cyc_pready", {31'd0, pready}, 32'd1);
    end

    // ---------------- stimulus ----------------
    task automatic xfer(input bit wr, input logic [9:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input bit ev, input logic [1:0] et,
                        input logic [AW-1:0] ea, output logic [31:0] rdv, output logic err);
        @(posedge clk); #2;
        psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
        @(posedge clk); #2;
        penable = 1; err_valid = ev; err_type = et; err_addr = ea;
        @(negedge clk);
        rdv = prdata; err = pslverr;
        @(posedge clk); #2;
        psel = 0; penable = 0; pwrite = 0; err_valid = 0;
    endtask

    task automatic rd_chk(input string name, input logic [9:0] a, input logic [31:0] exp);
        logic [31:0] v; logic e;
        xfer(0, a, 0, 4'hF, 0, 2'b00, '0, v, e);
        chk(name, v, exp);
    endtask

    task automatic wr_reg(input logic [9:0] a, input logic [31:0] d);
        logic [31:0] v; logic e;
        xfer(1, a, d, 4'hF, 0, 2'b00, '0, v, e);
    endtask

    task automatic ev(input logic [1:0] t, input logic [AW-1:0] ad);
        @(posedge clk); #2;
        err_valid = 1; err_type = t; err_addr = ad;
        @(posedge clk); #2;
        err_valid = 0;
    endtask

    initial begin
        logic [31:0] v; logic e;
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_irq", {31'd0, irq_o}, 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
        @(posedge clk); #2; rstn = 1;
        rd_chk("rst_status", 10'h000, 32'h04);
        rd_chk("rst_sec_cnt", 10'h008, 32'h0);

        // single SEC event
        ev(2'b01, 5'd5);
        rd_chk("sec_cnt_1", 10'h008, 32'h1);
        rd_chk("sec_status", 10'h000, 32'h01);
        rd_chk("sec_pop", 10'h010, 32'h8001_0005);
        rd_chk("sec_pop_empty", 10'h010, 32'h0);
        rd_chk("sec_status_empty", 10'h000, 32'h05);

        // DED interrupt and W1C
        wr_reg(10'h000, 32'h1);
        wr_reg(10'h004, 32'h2);
        ev(2'b10, 5'd3);
        @(posedge clk); @(negedge clk);
        chk("ded_irq_set", {31'd0, irq_o}, 32'd1);
        wr_reg(10'h000, 32'h2);
        @(negedge clk);
        chk("ded_irq_hold", {31'd0, irq_o}, 32'd1);
        @(negedge clk);
        chk("ded_irq_clr", {31'd0, irq_o}, 32'd0);
        rd_chk("ded_pop", 10'h010, 32'h8002_0003);

        // overflow: five events into a four-entry log
        for (int i = 0; i < 5; i++) ev(2'b01, 5'(10 + i));
        rd_chk("ovf_status", 10'h000, 32'h19);
        for (int i = 0; i < 4; i++) rd_chk("ovf_pop", 10'h010, 32'h8001_0000 | 32'(10 + i));
        rd_chk("ovf_pop_empty", 10'h010, 32'h0);

        // full log + event + pop on the same edge
        wr_reg(10'h000, 32'h13);
        for (int i = 0; i < 4; i++) ev(2'b01, 5'(20 + i));
        xfer(0, 10'h010, 0, 4'hF, 1, 2'b01, 5'd7, v, e);
        chk("pp_pop", v, 32'h8001_0014);
        rd_chk("pp_status", 10'h000, 32'h09);
        for (int i = 0; i < 3; i++) rd_chk("pp_pop_old", 10'h010, 32'h8001_0000 | 32'(21 + i));
        rd_chk("pp_pop_new", 10'h010, 32'h8001_0007);

        // ignored types, saturation, clears, unmapped access
        ev(2'b00, 5'd1);
        ev(2'b11, 5'd2);
        rd_chk("ign_ded_cnt", 10'h00C, 32'h1);
        rd_chk("ign_sec_cnt", 10'h008, 32'hB);
        for (int i = 0; i < 6; i++) ev(2'b01, 5'd9);
        rd_chk("sat_sec_cnt", 10'h008, CMAX);
        xfer(1, 10'h008, 0, 4'hF, 1, 2'b01, 5'd9, v, e);
        rd_chk("clr_evt_cnt", 10'h008, 32'h1);
        wr_reg(10'h008, 32'h0);
        rd_chk("clr_cnt", 10'h008, 32'h0);
        xfer(0, 10'h3FC, 0, 4'hF, 0, 2'b00, '0, v, e);
        chk("unmapped_err", {31'd0, e}, 32'd1);
        chk("unmapped_data", v, 32'd0);
        xfer(1, 10'h004, 32'h7, 4'hE, 0, 2'b00, '0, v, e);
        rd_chk("strb_irq_en", 10'h004, 32'h2);

        // soft reset with a pending interrupt and an in-flight write
        wr_reg(10'h004, 32'h7);
        ev(2'b01, 5'd4);
        @(posedge clk); @(negedge clk);
        chk("swr_irq_pre", {31'd0, irq_o}, 32'd1);
        @(posedge clk); #2;
        sw_rstn = 0; psel = 1; penable = 1; pwrite = 1; paddr = 10'h004; pwdata = 32'h7;
        @(posedge clk); #2;
        sw_rstn = 1; psel = 0; penable = 0; pwrite = 0;
        @(negedge clk);
        chk("swr_irq", {31'd0, irq_o}, 32'd0);
        rd_chk("swr_status", 10'h000, 32'h04);
        rd_chk("swr_irq_en", 10'h004, 32'h0);
        rd_chk("swr_sec_cnt", 10'h008, 32'h0);
        rd_chk("swr_ded_cnt", 10'h00C, 32'h0);
        rd_chk("swr_pop", 10'h010, 32'h0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
